// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - debounced single-button sequencer loading ALU operands and capturing the result
module alu_operand_loader #(
  parameter int data_size       = 7,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [data_size-1:0] sw,
  input  logic                 btn_load,
  input  logic [data_size:0]   result_in,
  output logic [data_size-1:0] data_a,
  output logic [data_size-1:0] data_b,
  output logic [5:0]           operation,
  output logic [data_size:0]   result_out,
  output logic                 result_valid,
  output logic [1:0]           state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t        cur, nxt;
  logic          s1, s2, db, db_q;
  logic [CW-1:0] cnt;
  logic          load_pulse;
  logic          cap_pend;
  logic          ld_a, ld_b, ld_op, clr_valid;

  // Counter only advances while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= btn_load;
      s2   <= s1;
      db_q <= db;
      if (s2 != db) begin
        if (cnt == CNT_MAX) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign load_pulse = db & ~db_q;

  always_comb begin
    nxt       = cur;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    clr_valid = 1'b0;
    case (cur)
      S_A: if (load_pulse) begin
        ld_a = 1'b1;
        nxt  = S_B;
      end
      S_B: if (load_pulse) begin
        ld_b = 1'b1;
        nxt  = S_OP;
      end
      S_OP: if (load_pulse) begin
        ld_op = 1'b1;
        nxt   = S_SHOW;
      end
      S_SHOW: if (load_pulse) begin
        ld_a      = 1'b1;
        clr_valid = 1'b1;
        nxt       = S_B;
      end
      default: nxt = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= S_A;
      data_a       <= '0;
      data_b       <= '0;
      operation    <= '0;
      result_out   <= '0;
      result_valid <= 1'b0;
      cap_pend     <= 1'b0;
    end else begin
      cur <= nxt;
      if (ld_a)  data_a    <= sw;
      if (ld_b)  data_b    <= sw;
      if (ld_op) operation <= sw[5:0];
      // The ALU settles on the new function code during the cycle after it loads.
      if (ld_op) begin
        cap_pend <= 1'b1;
      end else if (cap_pend) begin
        result_out   <= result_in;
        result_valid <= 1'b1;
        cap_pend     <= 1'b0;
      end
      if (clr_valid) result_valid <= 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end sequencer that sits directly upstream of the combinational ALU. It loads operand A, operand B and the 6-bit function code one after another from board switches. Each load is triggered by a single debounced push-button. It drives the three values to the ALU inputs, then registers the ALU result one cycle after the function code is loaded, for display on the LEDs.

## Interface
- `data_size`, 7, operand width. Must be ≥ 6. The result is `data_size+1` bits.
- `DEBOUNCE_CYCLES`, 50000, number of consecutive cycles the synchronized button level must differ before it is accepted. Must be ≥ 1.

- `clk`  in  1  single system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  `data_size`  switch bank, asynchronous to `clk`. Operands use all bits; the function code uses `sw[5:0]`.
- `btn_load`  in  1  raw push-button, active-high, bouncy, asynchronous.
- `result_in`  in  `data_size+1`  combinational result returned by the ALU.
- `data_a`  out  `data_size`  operand A to the ALU.
- `data_b`  out  `data_size`  operand B to the ALU.
- `operation`  out  6  function code to the ALU.
- `result_out`  out  `data_size+1`  registered ALU result.
- `result_valid`  out  1  high while `result_out` holds the result of the current A/B/op triple.
- `state`  out  2  current state (0 = S_A, 1 = S_B, 2 = S_OP, 3 = S_SHOW), drives the LEDs.

## Operation
- **Input conditioning**
  - `btn_load` passes through a 2-flop synchronizer, giving `s2`.
  - A debounce counter increments on every edge where `s2` ≠ `db` and clears on every edge where they are equal.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `s2` ≠ `db`, then `db <= s2` and the counter clears.
  - `load_pulse = db & ~db_q`, where `db_q` is `db` delayed by one cycle. It is exactly one cycle wide per accepted press. Releases generate no pulse.
- **FSM (4 states)**
  - S_A: on `load_pulse`, `data_a <= sw`, go to S_B.
  - S_B: on `load_pulse`, `data_b <= sw`, go to S_OP.
  - S_OP: on `load_pulse`, `operation <= sw[5:0]`, go to S_SHOW, set internal `cap_pend`.
  - S_SHOW: on the edge where `cap_pend` = 1, `result_out <= result_in`, `result_valid <= 1`, `cap_pend <= 0`.
  - S_SHOW: on a later `load_pulse`, `data_a <= sw`, `result_valid <= 0`, go to S_B. `result_out` holds its last value.
- Registers not being written hold their value in every state. The ALU inputs therefore stay stable between loads.
- Function codes are passed through unmodified, including unsupported ones. For those the ALU returns 0 and that value is captured normally.
- The sequencer does no arithmetic. `result_out` is `result_in` bit-for-bit. Sign and width interpretation belong to the ALU: for example, 3 − 5 at `data_size` = 7 yields 8'hFE.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-sequence) forces:
  - state = S_A;
  - `data_a`, `data_b`, `operation`, `result_out` = 0;
  - `result_valid` = 0;
  - synchronizer flops, `db`, `db_q`, counter and `cap_pend` = 0.
- Leaving reset: the first `clk` edge after `rst_n` rises behaves as a normal edge.
- Press latency: if raw `btn_load` rises and stays high from before edge E0, `db` rises at edge E0+`DEBOUNCE_CYCLES`+1. `load_pulse` is high for the following cycle, and the register capture plus state change occur at edge E0+`DEBOUNCE_CYCLES`+2.
- Glitches: any high or low excursion shorter than `DEBOUNCE_CYCLES` consecutive cycles (measured at `s2`) produces no pulse and no state change.
- Result capture: if `operation` loads at edge X, then `result_out` and `result_valid` update at edge X+1. `state` reads 3 from X onward.
- At most one capture occurs per pulse. A held button produces one pulse only.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4.

1. Reset: `rst_n` = 0 mid-run → all outputs 0 and `state` = 0 immediately, with no clock edge needed.
2. ADD: press with sw = 7'h05, then 7'h03, then 7'h20 (6'b100000); model ALU combinationally.
   - `data_a` = 05 and `data_b` = 03.
   - `operation` = 6'h20.
   - One edge after the op load: `result_out` = 8'h08, `result_valid` = 1, `state` = 3.
   - Each capture lands exactly 6 edges after the raw rise.
3. SUB wrap: A = 7'h03, B = 7'h05, op = 6'b100010 → `result_out` = 8'hFE.
4. Bounce:
   - Raw pulses of 1, 2 and 3 cycles separated by 2-cycle lows → no state change.
   - Following press held for 10 cycles → exactly one capture.
5. Re-entry: from S_SHOW with `result_out` = 8'h08, press with sw = 7'h7F.
   - `data_a` = 7F and `state` = 1.
   - `result_valid` = 0 on the same edge.
   - `result_out` still 8'h08.
6. Reset mid-sequence: after A and B are loaded (`state` = 2), assert `rst_n` = 0 → `state` = 0 and `data_a` = `data_b` = 0. The next press loads A again.
